// File: rtl/sdram_wr_ctrl_if.sv
// FIFO read side and SDRAM-controller burst-write port of sdram_wr_ctrl.
// The master modport is the controller's view; the slave modport is the FIFO/SDRAM side.
interface sdram_wr_ctrl_if #(
    parameter int ADDR_W  = 22,
    parameter int USEDW_W = 9
);
    logic [USEDW_W-1:0] wrf_usedw;
    logic [15:0]        wrf_dout;
    logic               wrf_rdreq;
    logic               sdwr_req;
    logic [ADDR_W-1:0]  sdwr_addr;
    logic               sdwr_ack;
    logic               sdwr_dreq;
    logic [15:0]        sdwr_data;

    modport master (
        input  wrf_usedw, wrf_dout, sdwr_ack, sdwr_dreq,
        output wrf_rdreq, sdwr_req, sdwr_addr, sdwr_data
    );

    modport slave (
        output wrf_usedw, wrf_dout, sdwr_ack, sdwr_dreq,
        input  wrf_rdreq, sdwr_req, sdwr_addr, sdwr_data
    );
endinterface

// File: rtl/sdram_wr_ctrl.sv
// Drains the capture write FIFO into fixed-length SDRAM write bursts at
// frame-linear addresses, ping-ponging between two frame banks.
module sdram_wr_ctrl #(
    parameter int BURST_LEN   = 8,
    parameter int ADDR_W      = 22,
    parameter int FRAME_WORDS = 307200,
    parameter int USEDW_W     = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    sdram_wr_ctrl_if.master bus,
    input  logic            frame_start,
    output logic            wr_bank,
    output logic            rd_bank,
    output logic            frame_done,
    output logic            err_udf
);
    localparam int AW = ADDR_W - 1;
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam logic [BW-1:0]      BEATS     = BW'(BURST_LEN);
    localparam logic [BW-1:0]      LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [AW:0]        FRAME_END = (AW + 1)'(FRAME_WORDS);
    localparam logic [AW:0]        STEP_X    = (AW + 1)'(BURST_LEN);
    localparam logic [AW-1:0]      STEP      = AW'(BURST_LEN);
    localparam logic [USEDW_W-1:0] NEED      = USEDW_W'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, DATA, UPD} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] word_addr, word_addr_nx;
    logic [BW-1:0] beat, beat_nx;
    logic          pending, pending_nx;
    logic          wr_bank_nx;
    logic          pop;
    logic          at_frame_end;

    assign pop          = (state == DATA) && bus.sdwr_dreq && (beat < BEATS);
    assign at_frame_end = ({1'b0, word_addr} + STEP_X) == FRAME_END;

    assign bus.wrf_rdreq = pop;
    assign bus.sdwr_data = bus.wrf_dout;
    assign bus.sdwr_req  = (state == REQ);
    assign rd_bank       = ~wr_bank;
    assign frame_done    = (state == UPD) && at_frame_end;

    always_comb begin
        state_nx     = state;
        word_addr_nx = word_addr;
        beat_nx      = beat;
        wr_bank_nx   = wr_bank;
        pending_nx   = pending | frame_start;
        case (state)
            IDLE: begin
                // A frame start while already at word 0 needs no realignment.
                if (word_addr == '0) pending_nx = 1'b0;
                if (bus.wrf_usedw >= NEED) state_nx = REQ;
            end
            REQ: begin
                if (bus.sdwr_ack) state_nx = DATA;
            end
            DATA: begin
                if (pop) begin
                    if (beat == LAST_BEAT) begin
                        beat_nx  = '0;
                        state_nx = UPD;
                    end else begin
                        beat_nx = beat + 1'b1;
                    end
                end
            end
            UPD: begin
                pending_nx = frame_start;
                if (at_frame_end || pending) begin
                    word_addr_nx = '0;
                    wr_bank_nx   = ~wr_bank;
                end else begin
                    word_addr_nx = word_addr + STEP;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= IDLE;
            word_addr     <= '0;
            beat          <= '0;
            pending       <= 1'b0;
            wr_bank       <= 1'b0;
            err_udf       <= 1'b0;
            bus.sdwr_addr <= '0;
        end else begin
            state     <= state_nx;
            word_addr <= word_addr_nx;
            beat      <= beat_nx;
            pending   <= pending_nx;
            wr_bank   <= wr_bank_nx;
            if (state == IDLE) bus.sdwr_addr <= {wr_bank, word_addr};
            if (pop && (bus.wrf_usedw == '0)) err_udf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_wr_ctrl.sv
// Randomized scoreboard bench for sdram_wr_ctrl: a FIFO model feeds bursts,
// a frame-level reference model predicts addresses, banks and frame_done.
module tb_sdram_wr_ctrl;
    localparam int BL = 8;
    localparam int AW = 22;
    localparam int FW = 32;
    localparam int UW = 9;

    logic clk         = 1'b0;
    logic rst_n       = 1'b1;
    logic frame_start = 1'b0;
    logic wr_bank, rd_bank, frame_done, err_udf;

    sdram_wr_ctrl_if #(.ADDR_W(AW), .USEDW_W(UW)) bus ();

    sdram_wr_ctrl #(
        .BURST_LEN(BL), .ADDR_W(AW), .FRAME_WORDS(FW), .USEDW_W(UW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .frame_start(frame_start),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_done(frame_done), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    int            n_vec        = 0;
    int            n_miscompare = 0;
    logic [15:0]   fifo_q[$];
    logic [15:0]   push_q[$];
    logic [15:0]   exp_data[$];
    logic [AW-1:0] exp_addr[$];
    bit            force_empty = 1'b0;
    bit            do_pop;
    logic          prev_req = 1'b0;
    int            pops     = 0;
    int            fd_seen  = 0;
    int            m_addr    = 0;
    bit            m_bank    = 1'b0;
    bit            m_pending = 1'b0;
    bit            m_err     = 1'b0;
    int            m_fd      = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miscompare++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic flag_fail(input string name, input string what);
        n_vec++;
        n_miscompare++;
        $display("[TB] FAIL %s: %s at %0t", name, what, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [AW-1:0] model_addr();
        logic [AW-1:0] a;
        a        = AW'(m_addr);
        a[AW-1]  = m_bank;
        return a;
    endfunction

    // Frame-level rules applied once a burst has been fully delivered.
    task automatic model_burst_done();
        if (m_addr + BL == FW) begin
            m_addr = 0;
            m_bank = ~m_bank;
            m_fd++;
        end else if (m_pending) begin
            m_addr = 0;
            m_bank = ~m_bank;
        end else begin
            m_addr += BL;
        end
        m_pending = 1'b0;
        exp_addr.push_back(model_addr());
    endtask

    // Show-ahead FIFO: pops sampled at the edge, contents refreshed just after it.
    always @(posedge clk) begin
        do_pop = bus.wrf_rdreq;
        #1;
        if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
        bus.wrf_usedw = force_empty ? '0 : UW'(fifo_q.size());
        bus.wrf_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            prev_req = 1'b0;
        end else begin
            if (bus.sdwr_req && !prev_req) begin
                if (exp_addr.size() == 0) flag_fail("sdwr_addr", "got request, expected none");
                else check_output("sdwr_addr", 32'(bus.sdwr_addr), 32'(exp_addr.pop_front()));
            end
            prev_req = bus.sdwr_req;
            if (bus.wrf_rdreq) begin
                pops++;
                if (exp_data.size() == 0) flag_fail("sdwr_data", "got pop, expected none");
                else check_output("sdwr_data", 32'(bus.sdwr_data), 32'(exp_data.pop_front()));
            end
            if (frame_done) fd_seen++;
        end
    end

    task automatic do_reset();
        frame_start  = 1'b0;
        bus.sdwr_ack  = 1'b0;
        bus.sdwr_dreq = 1'b0;
        force_empty  = 1'b0;
        rst_n        = 1'b1;
        tick();
        check_output("rst_sdwr_req", 32'(bus.sdwr_req), 0);
        check_output("rst_sdwr_addr", 32'(bus.sdwr_addr), 0);
        check_output("rst_wrf_rdreq", 32'(bus.wrf_rdreq), 0);
        check_output("rst_wr_bank", 32'(wr_bank), 0);
        check_output("rst_rd_bank", 32'(rd_bank), 1);
        check_output("rst_frame_done", 32'(frame_done), 0);
        check_output("rst_err_udf", 32'(err_udf), 0);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        m_addr    = 0;
        m_bank    = 1'b0;
        m_pending = 1'b0;
        m_err     = 1'b0;
        m_fd      = 0;
        fd_seen   = 0;
        exp_addr.delete();
        exp_addr.push_back(model_addr());
    endtask

    // One burst: fill the FIFO, grant the request, deliver BL data strobes.
    // mode 0 = contiguous dreq, 1 = 1,0,1,1,0 pattern, 2 = random gaps.
    task automatic apply_stimulus(input bit hold7, input bit idle_fs, input bit mid_fs,
                                  input int fs_beat, input int mode, input bit starve);
        int          waited;
        int          got;
        int          cyc;
        bit          fired;
        logic [15:0] w;
        logic [4:0]  pat;
        pat = 5'b01101;
        if (idle_fs) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            if (m_addr != 0) m_pending = 1'b1;
        end
        pops = 0;
        for (int i = 0; i < BL; i++) begin
            w = 16'($urandom);
            exp_data.push_back(w);
            push_q.push_back(w);
            if (hold7 && i == BL - 2) begin
                repeat (6) tick();
                check_output("req_below_burst", 32'(bus.sdwr_req), 0);
            end
        end
        waited = 0;
        while (!bus.sdwr_req && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.sdwr_req) begin
            flag_fail("req_timeout", "got no sdwr_req within 20 cycles, expected one");
            return;
        end
        if (hold7) check_output("req_latency_ok", 32'(waited <= 3), 1);
        repeat ($urandom_range(0, 3)) begin
            bus.sdwr_dreq = 1'($urandom_range(0, 1));
            tick();
            check_output("req_held", 32'(bus.sdwr_req), 1);
        end
        bus.sdwr_ack  = 1'b1;
        bus.sdwr_dreq = 1'($urandom_range(0, 1));
        tick();
        bus.sdwr_ack = 1'b0;
        check_output("req_drop_after_ack", 32'(bus.sdwr_req), 0);
        got   = 0;
        cyc   = 0;
        fired = 1'b0;
        while (got < BL && cyc < 200) begin
            case (mode)
                0:       bus.sdwr_dreq = 1'b1;
                1:       bus.sdwr_dreq = pat[3'(cyc % 5)];
                default: bus.sdwr_dreq = ($urandom_range(0, 2) != 0);
            endcase
            frame_start = mid_fs && !fired && (got == fs_beat);
            if (frame_start) begin
                fired     = 1'b1;
                m_pending = 1'b1;
            end
            if (starve && got == 2) begin
                force_empty = 1'b1;
                m_err       = 1'b1;
            end
            tick();
            if (bus.sdwr_dreq) got++;
            cyc++;
        end
        frame_start = 1'b0;
        if (got < BL) flag_fail("dreq_budget", "got fewer than BL strobes in 200 cycles");
        bus.sdwr_dreq = 1'b1;
        tick();
        bus.sdwr_dreq = 1'b0;
        force_empty   = 1'b0;
        model_burst_done();
        repeat (3) tick();
        check_output("pops_per_burst", 32'(pops), BL);
        check_output("wr_bank", 32'(wr_bank), 32'(m_bank));
        check_output("rd_bank", 32'(rd_bank), 32'(!m_bank));
        check_output("frame_done_count", 32'(fd_seen), 32'(m_fd));
        check_output("err_udf", 32'(err_udf), 32'(m_err));
    endtask

    initial begin
        bus.sdwr_ack  = 1'b0;
        bus.sdwr_dreq = 1'b0;
        bus.wrf_usedw = '0;
        bus.wrf_dout  = '0;
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 0, 2, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4, 0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 0, 2, 1'b0);
        for (int n = 0; n < 40; n++) begin
            apply_stimulus(1'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                           int'($urandom_range(0, BL - 1)), 2, 1'b0);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        repeat (5) tick();
        check_output("err_udf_sticky", 32'(err_udf), 1);
        do_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0, 0, 2, 1'b0);
        check_output("data_queue_drained", 32'(exp_data.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected one");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/sdram_wr_ctrl.md
Name: sdram_wr_ctrl

Overview:
- Downstream neighbour of the video capture path. Drains the SDRAM write-buffer FIFO that video_ctrl fills via wrf_din/wrf_wrreq.
- Issues fixed-length burst write requests to the SDRAM controller and generates frame-linear write addresses.
- Ping-pongs between two frame banks so the display side always reads a complete frame.
- Runs in the 100 MHz SDRAM clock domain, on the FIFO read side.

Parameters:
- BURST_LEN, 8, words per SDRAM write burst (power of two, 2..256)
- ADDR_W, 22, SDRAM word-address width; MSB is the bank select
- FRAME_WORDS, 307200, 16-bit words per frame (640x480); must be a multiple of BURST_LEN
- USEDW_W, 9, width of the FIFO used-words count

Ports:
- clk  in  1  100 MHz SDRAM-domain clock
- rst_n  in  1  asynchronous reset, active-high (1 = reset)
- wrf_usedw  in  USEDW_W  FIFO read-side used-words count
- wrf_dout  in  16  FIFO read data; show-ahead, valid whenever the FIFO is not empty
- wrf_rdreq  out  1  FIFO pop, one word per high cycle
- frame_start  in  1  one-cycle pulse at capture frame start (already synchronised to clk)
- sdwr_req  out  1  burst write request to the SDRAM controller
- sdwr_addr  out  ADDR_W  burst start word address, stable while sdwr_req=1
- sdwr_ack  in  1  one-cycle grant from the controller
- sdwr_dreq  in  1  controller data strobe; high for BURST_LEN cycles (not necessarily contiguous) after ack
- sdwr_data  out  16  burst write data
- wr_bank  out  1  bank currently being written
- rd_bank  out  1  last completed bank (= ~wr_bank), for the display reader
- frame_done  out  1  one-cycle pulse when a frame's last burst completes
- err_udf  out  1  sticky: a pop was attempted while wrf_usedw==0

Behaviour:
- Reset (asynchronous, while rst_n=1): all outputs 0 except rd_bank=1; FSM=IDLE; word_addr=0; beat count=0; frame_start pending flag cleared.
- FSM has four states: IDLE, REQ, DATA, UPD.
- IDLE:
  - If wrf_usedw >= BURST_LEN, go to REQ on the next edge.
  - Also in that cycle, register sdwr_addr = {wr_bank, word_addr[ADDR_W-2:0]}.
- REQ:
  - sdwr_req=1; sdwr_addr held.
  - On sdwr_ack=1, go to DATA and drop sdwr_req the next cycle.
  - Request-to-ack latency is unbounded; no timeout.
- DATA:
  - wrf_rdreq = sdwr_dreq & (beat < BURST_LEN), combinational.
  - sdwr_data = wrf_dout, combinational.
  - beat increments on each accepted dreq.
  - When beat reaches BURST_LEN, go to UPD and clear beat.
  - dreq asserted outside DATA, or beyond BURST_LEN beats, is ignored: no pop, no count.
- UPD (exactly one cycle), evaluated in priority order:
  1. If word_addr + BURST_LEN == FRAME_WORDS: word_addr=0, toggle wr_bank, rd_bank=~new wr_bank, frame_done=1 for this cycle.
  2. Else, if the frame_start flag is pending: word_addr=0, toggle wr_bank (the partial frame is abandoned), no frame_done.
  3. Else: word_addr += BURST_LEN.
  - The pending flag is cleared in UPD in every case. Return to IDLE.
- frame_start handling:
  - A pulse in any state sets the pending flag.
  - In IDLE with word_addr==0, the flag is cleared without a bank toggle (frame already aligned).
  - A pulse during REQ/DATA never alters the burst in flight; it takes effect in UPD.
- Minimum gap: at least one IDLE cycle between bursts, so back-to-back bursts take BURST_LEN+3 cycles with immediate ack and contiguous dreq.
- err_udf: set when wrf_rdreq=1 while wrf_usedw==0; cleared only by reset.
- Address arithmetic: word_addr is ADDR_W-1 bits wide; FRAME_WORDS must fit in it, otherwise the configuration is illegal.
- Reset mid-burst: everything returns to reset values immediately; the FIFO is not flushed by this block.

Test Plan:
1. Reset, then hold wrf_usedw=7 -> sdwr_req stays 0. Set usedw=8 -> sdwr_req=1 within 2 cycles with sdwr_addr=0x000000.
2. ack, then 8 contiguous dreq, using FIFO data 0x1000..0x1007 -> exactly 8 wrf_rdreq pulses and sdwr_data matches in order. The next burst carries sdwr_addr=0x000008.
3. Non-contiguous dreq (pattern 1,0,1,1,0,...) -> pops occur only on dreq cycles. An extra dreq after beat 8 causes no pop.
4. FRAME_WORDS=32, BURST_LEN=8, run 4 bursts -> frame_done pulses once after the 4th burst, wr_bank 0->1, rd_bank 1->0, next sdwr_addr=0x200000.
5. frame_start pulse in the middle of the 2nd burst -> that burst completes at addr 8, then word_addr=0, wr_bank toggles, frame_done stays 0.
6. Force wrf_usedw=0 during DATA while dreq=1 -> err_udf=1 and stays 1 until rst_n pulses high.
